// File: rtl/lbr_drain_unit_if.sv
// rtl/lbr_drain_unit_if.sv - control, LBR read port and entry stream bundle of the LBR drain unit
interface lbr_drain_unit_if #(
   parameter int DATA_WIDTH = 64,
   parameter int LBR_SIZE   = 16,
   parameter int IDX_W      = $clog2(LBR_SIZE),
   parameter int SEL_W      = $clog2(LBR_SIZE) + 2
);
   logic                  start;
   logic                  busy;
   logic                  done;
   logic                  lbr_freeze;
   logic [SEL_W-1:0]      lbr_read_sel;
   logic [DATA_WIDTH-1:0] lbr_read_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [IDX_W-1:0]      out_index;
   logic [DATA_WIDTH-1:0] out_from;
   logic [DATA_WIDTH-1:0] out_to;
   logic                  out_last;

   modport master (
      input  start, lbr_read_data, out_ready,
      output busy, done, lbr_freeze, lbr_read_sel,
             out_valid, out_index, out_from, out_to, out_last
   );

   modport slave (
      output start, lbr_read_data, out_ready,
      input  busy, done, lbr_freeze, lbr_read_sel,
             out_valid, out_index, out_from, out_to, out_last
   );
endinterface

// File: rtl/lbr_drain_unit.sv
// rtl/lbr_drain_unit.sv - freezes the LBR file and streams all from/to pairs oldest to newest
module lbr_drain_unit #(
   parameter int DATA_WIDTH = 64,
   parameter int LBR_SIZE   = 16,
   parameter int IDX_W      = $clog2(LBR_SIZE),
   parameter int SEL_W      = $clog2(LBR_SIZE) + 2
) (
   input  logic           clock,
   input  logic           reset,
   lbr_drain_unit_if.master bus
);
   typedef enum logic [2:0] {
      IDLE,
      RD_TOS,
      RD_FROM,
      RD_TO,
      SEND,
      DONE
   } state_t;

   localparam logic [SEL_W-1:0] TOS_SEL  = {1'b1, {(SEL_W-1){1'b0}}};
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LBR_SIZE - 1);

   state_t                state, state_nxt;
   logic [IDX_W-1:0]      ptr, ptr_nxt;
   logic [IDX_W-1:0]      cnt, cnt_nxt;
   logic [IDX_W-1:0]      slot;
   logic [DATA_WIDTH-1:0] from_q, from_nxt;
   logic [DATA_WIDTH-1:0] to_q, to_nxt;

   always_ff @(posedge clock) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         cnt    <= '0;
         from_q <= '0;
         to_q   <= '0;
      end else begin
         state  <= state_nxt;
         ptr    <= ptr_nxt;
         cnt    <= cnt_nxt;
         from_q <= from_nxt;
         to_q   <= to_nxt;
      end
   end

   // TOS names the next slot to be written, which is the oldest live entry
   assign slot = ptr + cnt;

   always_comb begin
      state_nxt        = state;
      ptr_nxt          = ptr;
      cnt_nxt          = cnt;
      from_nxt         = from_q;
      to_nxt           = to_q;
      bus.lbr_read_sel = TOS_SEL;
      bus.out_valid    = 1'b0;
      bus.done         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) state_nxt = RD_TOS;
         end
         RD_TOS: begin
            ptr_nxt   = bus.lbr_read_data[IDX_W-1:0];
            cnt_nxt   = '0;
            state_nxt = RD_FROM;
         end
         RD_FROM: begin
            bus.lbr_read_sel = {2'b00, slot};
            from_nxt         = bus.lbr_read_data;
            state_nxt        = RD_TO;
         end
         RD_TO: begin
            bus.lbr_read_sel = {2'b01, slot};
            to_nxt           = bus.lbr_read_data;
            state_nxt        = SEND;
         end
         SEND: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) begin
               if (cnt == LAST_IDX) begin
                  state_nxt = DONE;
               end else begin
                  cnt_nxt   = cnt + 1'b1;
                  state_nxt = RD_FROM;
               end
            end
         end
         DONE: begin
            bus.done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign bus.busy       = (state != IDLE);
   assign bus.lbr_freeze = (state != IDLE);
   assign bus.out_index  = cnt;
   assign bus.out_from   = from_q;
   assign bus.out_to     = to_q;
   assign bus.out_last   = (state == SEND) && (cnt == LAST_IDX);
endmodule

// File: tb/tb_lbr_drain_unit.sv
// tb/tb_lbr_drain_unit.sv - randomized and directed bench for lbr_drain_unit with an LBR file model
module tb_lbr_drain_unit;
   localparam int DW = 64;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int SW = 4;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   lbr_drain_unit_if #(.DATA_WIDTH(DW), .LBR_SIZE(N)) bus ();

   lbr_drain_unit #(.DATA_WIDTH(DW), .LBR_SIZE(N)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // LBR register file model
   logic [DW-1:0] lbr_from [N];
   logic [DW-1:0] lbr_to   [N];
   logic [DW-1:0] lbr_tos;

   always_comb begin
      bus.lbr_read_data = '0;
      if (bus.lbr_read_sel[SW-1])      bus.lbr_read_data = lbr_tos;
      else if (bus.lbr_read_sel[SW-2]) bus.lbr_read_data = lbr_to[bus.lbr_read_sel[IW-1:0]];
      else                             bus.lbr_read_data = lbr_from[bus.lbr_read_sel[IW-1:0]];
   end

   logic start_drv = 1'b0;
   logic ready_drv = 1'b1;
   assign bus.start     = start_drv;
   assign bus.out_ready = ready_drv;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   // sink behaviour: 0 always ready, 1 random, 2 stall entry 1 for 5 cycles, 3 never accept entry 2
   int ready_mode = 0;
   int stall = 0;
   always @(posedge clock) begin
      #1;
      if (ready_mode != 2) stall = 0;
      case (ready_mode)
         0: ready_drv = 1'b1;
         1: ready_drv = 1'($urandom_range(0, 1));
         2: begin
            if (bus.out_valid && bus.out_index == 2'd1 && stall < 5) begin
               ready_drv = 1'b0;
               stall++;
            end else begin
               ready_drv = 1'b1;
            end
         end
         default: ready_drv = !(bus.out_valid && bus.out_index == 2'd2);
      endcase
   end

   // reference model: a dump is a list of N pairs starting at slot TOS mod N
   logic          dump_active = 1'b0;
   bit            run_tied = 1'b0;
   int            start_cyc = 0;
   int            exp_idx = 0;
   int            off = 0;
   int            done_cnt = 0;
   int            done_off = -1;
   logic [DW-1:0] exp_from [$];
   logic [DW-1:0] exp_to   [$];
   logic [DW-1:0] got_from [N];
   logic [DW-1:0] got_to   [N];
   int            hs_off   [N];
   bit            log_sel = 1'b0;
   logic [SW-1:0] sel_log  [16];
   logic          prev_valid = 1'b0, prev_ready = 1'b0, prev_reset = 1'b1, prev_last = 1'b0;
   logic [IW-1:0] prev_index = '0;
   logic [DW-1:0] prev_from = '0, prev_to = '0;

   always @(negedge clock) begin
      if (reset) begin
         exp_from.delete();
         exp_to.delete();
         dump_active = 1'b0;
      end else begin
         if (!dump_active && bus.start) begin
            dump_active = 1'b1;
            start_cyc   = cyc;
            run_tied    = (ready_mode == 0);
            exp_idx     = 0;
            for (int i = 0; i < N; i++) begin
               int s;
               s = (int'(lbr_tos[IW-1:0]) + i) % N;
               exp_from.push_back(lbr_from[s]);
               exp_to.push_back(lbr_to[s]);
            end
         end
         off = cyc - start_cyc;
         chk("busy", 64'(bus.busy), 64'(dump_active && off > 0));
         chk("freeze", 64'(bus.lbr_freeze), 64'(dump_active && off > 0));
         if (log_sel && dump_active && off < 16) sel_log[off] = bus.lbr_read_sel;
         if (!dump_active) chk("idle_valid", 64'(bus.out_valid), 64'd0);
         if (prev_valid && !prev_ready && !prev_reset) begin
            chk("hold_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_from", bus.out_from, prev_from);
            chk("hold_to", bus.out_to, prev_to);
            chk("hold_index", 64'(bus.out_index), 64'(prev_index));
            chk("hold_last", 64'(bus.out_last), 64'(prev_last));
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_from.size() == 0) begin
               chk("extra_entry", 64'(bus.out_valid), 64'd0);
            end else begin
               chk("from", bus.out_from, exp_from.pop_front());
               chk("to", bus.out_to, exp_to.pop_front());
               chk("index", 64'(bus.out_index), 64'(exp_idx));
               chk("last", 64'(bus.out_last), 64'(exp_idx == N - 1));
               if (run_tied) chk("entry_latency", 64'(off), 64'(4 + 3 * exp_idx));
               got_from[exp_idx] = bus.out_from;
               got_to[exp_idx]   = bus.out_to;
               hs_off[exp_idx]   = off;
               exp_idx++;
            end
         end
         if (bus.done) begin
            chk("done_expected", 64'(dump_active), 64'd1);
            chk("done_pending", 64'(exp_from.size()), 64'd0);
            if (run_tied) chk("done_latency", 64'(off), 64'(3 * N + 2));
            done_off    = off;
            dump_active = 1'b0;
            done_cnt++;
         end
      end
      prev_valid = bus.out_valid;
      prev_ready = bus.out_ready;
      prev_reset = reset;
      prev_index = bus.out_index;
      prev_from  = bus.out_from;
      prev_to    = bus.out_to;
      prev_last  = bus.out_last;
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic pulse_start();
      tick();
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
   endtask

   task automatic wait_dones(input int target);
      int budget;
      budget = 400;
      while (done_cnt < target && budget > 0) begin
         // writes while frozen must be suppressed by the LBR writer
         if (!bus.lbr_freeze) begin end
         else if ($urandom_range(0, 3) == 0) begin end
         tick();
         budget--;
      end
      if (done_cnt < target) chk("done_timeout", 64'(done_cnt), 64'(target));
   endtask

   task automatic try_write(input int k, input logic [DW-1:0] f, input logic [DW-1:0] t);
      if (!bus.lbr_freeze) begin
         lbr_from[k] = f;
         lbr_to[k]   = t;
      end
   endtask

   task automatic all_outputs_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_last"}, 64'(bus.out_last), 64'd0);
      chk({tag, "_index"}, 64'(bus.out_index), 64'd0);
      chk({tag, "_from"}, bus.out_from, 64'd0);
      chk({tag, "_to"}, bus.out_to, 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
      chk({tag, "_done"}, 64'(bus.done), 64'd0);
      chk({tag, "_freeze"}, 64'(bus.lbr_freeze), 64'd0);
   endtask

   initial begin
      int base;
      int budget;
      for (int i = 0; i < N; i++) begin
         lbr_from[i] = 64'h100 + 64'(i);
         lbr_to[i]   = 64'h200 + 64'(i);
      end
      lbr_tos = '0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      all_outputs_zero("reset");
      tick();
      reset = 1'b0;

      // basic dump, TOS = 0
      ready_mode = 0;
      pulse_start();
      wait_dones(1);
      for (int i = 0; i < N; i++) begin
         chk("basic_from", got_from[i], 64'h100 + 64'(i));
         chk("basic_to", got_to[i], 64'h200 + 64'(i));
      end
      chk("basic_done_off", 64'(done_off), 64'd14);

      // wrap-around, TOS = 6 selects slot 2 first
      lbr_tos = 64'd6;
      log_sel = 1'b1;
      pulse_start();
      wait_dones(2);
      log_sel = 1'b0;
      chk("wrap_from0", got_from[0], 64'h102);
      chk("wrap_from1", got_from[1], 64'h103);
      chk("wrap_from2", got_from[2], 64'h100);
      chk("wrap_from3", got_from[3], 64'h101);
      chk("sel_tos", 64'(sel_log[1]), 64'h8);
      chk("sel_f2", 64'(sel_log[2]), 64'h2);
      chk("sel_t2", 64'(sel_log[3]), 64'h6);
      chk("sel_f3", 64'(sel_log[5]), 64'h3);
      chk("sel_t3", 64'(sel_log[6]), 64'h7);
      chk("sel_f0", 64'(sel_log[8]), 64'h0);
      chk("sel_t0", 64'(sel_log[9]), 64'h4);
      chk("sel_f1", 64'(sel_log[11]), 64'h1);
      chk("sel_t1", 64'(sel_log[12]), 64'h5);

      // backpressure on entry 1
      lbr_tos = '0;
      tick();
      ready_mode = 2;
      pulse_start();
      wait_dones(3);
      chk("bp_stall_cycles", 64'(stall), 64'd5);
      chk("bp_handshake_off", 64'(hs_off[1]), 64'd12);
      tick();
      ready_mode = 0;

      // start while busy, then start held across DONE into the next IDLE cycle
      base = done_cnt;
      pulse_start();
      repeat (4) tick();
      start_drv = 1'b1;
      tick();
      start_drv = 1'b0;
      budget = 100;
      while (!bus.done && budget > 0) begin
         tick();
         budget--;
      end
      chk("done_seen", 64'(bus.done), 64'd1);
      start_drv = 1'b1;
      tick();
      tick();
      start_drv = 1'b0;
      wait_dones(base + 2);
      repeat (8) tick();
      chk("no_extra_dump", 64'(done_cnt), 64'(base + 2));

      // reset while entry 2 is waiting on the sink
      ready_mode = 3;
      base = done_cnt;
      pulse_start();
      budget = 100;
      while (!(bus.out_valid && bus.out_index == 2'd2) && budget > 0) begin
         tick();
         budget--;
      end
      chk("entry2_valid", 64'(bus.out_valid), 64'd1);
      reset = 1'b1;
      tick();
      all_outputs_zero("midreset");
      reset = 1'b0;
      ready_mode = 0;
      repeat (3) tick();
      chk("midreset_no_done", 64'(done_cnt), 64'(base));
      pulse_start();
      wait_dones(base + 1);

      // randomized contents, TOS and sink behaviour; writes land in the start cycle
      for (int it = 0; it < 20; it++) begin
         base = done_cnt;
         tick();
         ready_mode = int'($urandom_range(0, 1));
         tick();
         for (int i = 0; i < N; i++) try_write(i, {$urandom, $urandom}, {$urandom, $urandom});
         lbr_tos   = {$urandom, $urandom};
         start_drv = 1'b1;
         tick();
         start_drv = 1'b0;
         budget = 400;
         while (done_cnt < base + 1 && budget > 0) begin
            try_write(int'($urandom_range(0, N - 1)), {$urandom, $urandom}, {$urandom, $urandom});
            tick();
            budget--;
         end
         if (done_cnt < base + 1) chk("rand_timeout", 64'(done_cnt), 64'(base + 1));
      end

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
